// File: rtl/ysyx_22040931_pipe_ctrl.sv
// Central pipeline controller: per-stage stall/flush, mispredict redirect
// (held across a busy fetch), and branch/stall performance counters.
module ysyx_22040931_pipe_ctrl #(
   parameter int PC_W  = 64,
   parameter int CNT_W = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             id_valid,
   input  logic             load_stall,
   input  logic             error_pre,
   input  logic             mux_pc,
   input  logic [1:0]       jumptype,
   input  logic [PC_W-1:0]  pc_id,
   input  logic [PC_W-1:0]  branch,
   input  logic             if_busy,
   input  logic             mem_busy,
   output logic             stall_if,
   output logic             stall_id,
   output logic             stall_ex,
   output logic             stall_mem,
   output logic             flush_id,
   output logic             flush_ex,
   output logic             redirect_valid,
   output logic [PC_W-1:0]  redirect_pc,
   output logic [CNT_W-1:0] br_total,
   output logic [CNT_W-1:0] br_correct,
   output logic [CNT_W-1:0] stall_cycles
);

   typedef enum logic {
      RUN        = 1'b0,
      REDIR_PEND = 1'b1
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [PC_W-1:0]   pend_pc;
   logic [PC_W-1:0]   pend_pc_next;
   logic [PC_W-1:0]   target_pc;
   logic              id_advance;
   logic              br_event;
   logic              stall_event;

   // Counters stick at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Corrected fetch PC for a mispredicted branch; fall-through wraps modulo 2^PC_W.
   always_comb begin
      target_pc = mux_pc ? branch : pc_id + PC_W'(4);
   end

   // Next-state and combinational stall/flush/redirect decode.
   always_comb begin
      state_next     = state;
      pend_pc_next   = pend_pc;
      stall_if       = 1'b0;
      stall_id       = 1'b0;
      stall_ex       = 1'b0;
      stall_mem      = 1'b0;
      flush_id       = 1'b0;
      flush_ex       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      if (!reset) begin
         // Bubble both decode registers while reset is held.
         flush_id     = 1'b1;
         flush_ex     = 1'b1;
         state_next   = RUN;
         pend_pc_next = '0;
      end else begin
         unique case (state)
            RUN: begin
               if (mem_busy) begin
                  // Whole pipe freezes; ID is re-evaluated once memory completes.
                  stall_if  = 1'b1;
                  stall_id  = 1'b1;
                  stall_ex  = 1'b1;
                  stall_mem = 1'b1;
               end else if (load_stall && id_valid) begin
                  // Operands are stale, so any mispredict flag is not trusted yet.
                  stall_if = 1'b1;
                  stall_id = 1'b1;
                  flush_ex = 1'b1;
               end else if (error_pre && id_valid) begin
                  redirect_valid = 1'b1;
                  redirect_pc    = target_pc;
                  flush_id       = 1'b1;
                  if (if_busy) begin
                     pend_pc_next = target_pc;
                     state_next   = REDIR_PEND;
                  end
               end else if (if_busy) begin
                  stall_if = 1'b1;
                  flush_id = 1'b1;
               end
            end
            REDIR_PEND: begin
               // Keep offering the latched target until fetch can accept it.
               redirect_valid = 1'b1;
               redirect_pc    = pend_pc;
               flush_id       = 1'b1;
               if (mem_busy) begin
                  stall_if  = 1'b1;
                  stall_id  = 1'b1;
                  stall_ex  = 1'b1;
                  stall_mem = 1'b1;
               end else if (!if_busy) begin
                  state_next = RUN;
               end
            end
            default: state_next = RUN;
         endcase
      end
   end

   // State and pending-redirect registers.
   always_ff @(posedge clock) begin
      state   <= state_next;
      pend_pc <= pend_pc_next;
   end

   // Qualifying events for the performance counters.
   always_comb begin
      id_advance  = (state == RUN) && !mem_busy && !load_stall;
      br_event    = id_valid && (jumptype != 2'd0) && id_advance;
      stall_event = mem_busy || (load_stall && id_valid);
   end

   // Saturating performance counters.
   always_ff @(posedge clock) begin
      if (!reset) begin
         br_total     <= '0;
         br_correct   <= '0;
         stall_cycles <= '0;
      end else begin
         if (br_event) begin
            br_total <= sat_inc(br_total);
         end
         if (br_event && !error_pre) begin
            br_correct <= sat_inc(br_correct);
         end
         if (stall_event) begin
            stall_cycles <= sat_inc(stall_cycles);
         end
      end
   end

endmodule

// File: tb/tb_ysyx_22040931_pipe_ctrl.sv
// Directed bench for the pipeline controller; a narrow-counter copy covers saturation.
module tb_ysyx_22040931_pipe_ctrl;

   localparam int PC_W  = 64;
   localparam int CNT_W = 32;
   localparam int SW    = 3;

   logic             clock;
   logic             reset;
   logic             id_valid;
   logic             load_stall;
   logic             error_pre;
   logic             mux_pc;
   logic [1:0]       jumptype;
   logic [PC_W-1:0]  pc_id;
   logic [PC_W-1:0]  branch;
   logic             if_busy;
   logic             mem_busy;
   logic             stall_if, stall_id, stall_ex, stall_mem;
   logic             flush_id, flush_ex, redirect_valid;
   logic [PC_W-1:0]  redirect_pc;
   logic [CNT_W-1:0] br_total, br_correct, stall_cycles;

   logic             s_stall_if, s_stall_id, s_stall_ex, s_stall_mem;
   logic             s_flush_id, s_flush_ex, s_redirect_valid;
   logic [PC_W-1:0]  s_redirect_pc;
   logic [SW-1:0]    s_br_total, s_br_correct, s_stall_cycles;

   int errors = 0;
   int checks = 0;

   ysyx_22040931_pipe_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
      .clock(clock), .reset(reset), .id_valid(id_valid), .load_stall(load_stall),
      .error_pre(error_pre), .mux_pc(mux_pc), .jumptype(jumptype), .pc_id(pc_id),
      .branch(branch), .if_busy(if_busy), .mem_busy(mem_busy),
      .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
      .flush_id(flush_id), .flush_ex(flush_ex), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .br_total(br_total), .br_correct(br_correct),
      .stall_cycles(stall_cycles)
   );

   ysyx_22040931_pipe_ctrl #(.PC_W(PC_W), .CNT_W(SW)) dut_sat (
      .clock(clock), .reset(reset), .id_valid(id_valid), .load_stall(load_stall),
      .error_pre(error_pre), .mux_pc(mux_pc), .jumptype(jumptype), .pc_id(pc_id),
      .branch(branch), .if_busy(if_busy), .mem_busy(mem_busy),
      .stall_if(s_stall_if), .stall_id(s_stall_id), .stall_ex(s_stall_ex), .stall_mem(s_stall_mem),
      .flush_id(s_flush_id), .flush_ex(s_flush_ex), .redirect_valid(s_redirect_valid),
      .redirect_pc(s_redirect_pc), .br_total(s_br_total), .br_correct(s_br_correct),
      .stall_cycles(s_stall_cycles)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Control outputs packed as {stall_if,stall_id,stall_ex,stall_mem,flush_id,flush_ex,redirect_valid}.
   logic [6:0] ctl;
   assign ctl = {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, redirect_valid};

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle();
      id_valid = 0; load_stall = 0; error_pre = 0; mux_pc = 0; jumptype = 2'd0;
      pc_id = '0; branch = '0; if_busy = 0; mem_busy = 0;
   endtask

   initial begin
      reset = 0;
      idle();
      // Reset outputs, with a live mispredict on the inputs that must be ignored.
      id_valid = 1; error_pre = 1; if_busy = 1; pc_id = 64'h80000010;
      settle();
      chk("reset_ctl", ctl, 7'b0000110);
      chk("reset_rpc", redirect_pc, 64'h0);
      tick(); tick();
      chk("reset_brt", br_total, 0);
      chk("reset_stc", stall_cycles, 0);

      reset = 1;
      idle();
      settle();
      chk("idle_ctl", ctl, 7'b0);

      // Mispredict with idle fetch: fall-through target, stays in RUN.
      id_valid = 1; error_pre = 1; mux_pc = 0; pc_id = 64'h80000010;
      branch = 64'h80000100; jumptype = 2'd1;
      settle();
      chk("mp_idle_ctl", ctl, 7'b0000101);
      chk("mp_idle_rpc", redirect_pc, 64'h80000014);
      tick();
      idle();
      settle();
      chk("mp_idle_run", ctl, 7'b0);
      chk("mp_idle_brt", br_total, 1);
      chk("mp_idle_brc", br_correct, 0);

      // Fall-through wraps at the top of the address space.
      id_valid = 1; error_pre = 1; mux_pc = 0; pc_id = 64'hFFFFFFFFFFFFFFFC;
      settle();
      chk("wrap_rpc", redirect_pc, 64'h0);
      idle();
      tick();

      // Mispredict during busy fetch: latched taken target held for 4 cycles.
      id_valid = 1; error_pre = 1; mux_pc = 1; branch = 64'h80000100;
      pc_id = 64'h80000040; jumptype = 2'd2; if_busy = 1;
      settle();
      chk("pend0_ctl", ctl, 7'b0000101);
      chk("pend0_rpc", redirect_pc, 64'h80000100);
      tick();
      idle(); if_busy = 1; branch = 64'hDEAD; mux_pc = 1;
      settle();
      chk("pend1_ctl", ctl, 7'b0000101);
      chk("pend1_rpc", redirect_pc, 64'h80000100);
      tick();
      // ID events ignored while pending; no branch counted here.
      id_valid = 1; error_pre = 1; jumptype = 2'd1; mux_pc = 0; pc_id = 64'h100;
      settle();
      chk("pend2_ctl", ctl, 7'b0000101);
      chk("pend2_rpc", redirect_pc, 64'h80000100);
      tick();
      idle();
      settle();
      chk("pend3_ctl", ctl, 7'b0000101);
      chk("pend3_rpc", redirect_pc, 64'h80000100);
      tick();
      settle();
      chk("pend_exit_ctl", ctl, 7'b0);
      chk("pend_brt", br_total, 2);
      chk("pend_brc", br_correct, 0);

      // Load-use hazard overrides a bogus mispredict.
      id_valid = 1; load_stall = 1; error_pre = 1; jumptype = 2'd1;
      settle();
      chk("lu_ctl", ctl, 7'b1100010);
      tick();
      idle();
      settle();
      chk("lu_stc", stall_cycles, 1);
      chk("lu_brt", br_total, 2);

      // mem_busy dominates everything for 5 cycles.
      for (int i = 0; i < 5; i++) begin
         mem_busy = 1; load_stall = 1; error_pre = 1; id_valid = 1; jumptype = 2'd3;
         if_busy = 1;
         settle();
         chk($sformatf("mb_ctl%0d", i), ctl, 7'b1111000);
         tick();
      end
      idle();
      settle();
      chk("mb_stc", stall_cycles, 6);
      chk("mb_brt", br_total, 2);
      chk("mb_brc", br_correct, 0);

      // Fetch busy alone bubbles ID.
      if_busy = 1;
      settle();
      chk("ifb_ctl", ctl, 7'b1000100);
      tick();
      idle();

      // Correctly predicted jumps; narrow copy saturates at 7.
      for (int i = 0; i < 9; i++) begin
         id_valid = 1; jumptype = 2'd3;
         settle();
         chk($sformatf("ok_ctl%0d", i), ctl, 7'b0);
         tick();
      end
      idle();
      settle();
      chk("ok_brt", br_total, 11);
      chk("ok_brc", br_correct, 9);
      chk("sat_brt", s_br_total, 7);
      chk("sat_brc", s_br_correct, 7);
      chk("sat_stc", s_stall_cycles, 6);
      id_valid = 1; jumptype = 2'd1;
      tick();
      idle();
      settle();
      chk("sat_brt_hold", s_br_total, 7);
      chk("ok_brt2", br_total, 12);

      // Reset while a redirect is pending discards it.
      id_valid = 1; error_pre = 1; mux_pc = 1; branch = 64'h80000200; jumptype = 2'd1;
      if_busy = 1;
      tick();
      idle(); if_busy = 1;
      settle();
      chk("rp_pend_rpc", redirect_pc, 64'h80000200);
      reset = 0;
      settle();
      chk("rp_rst_ctl", ctl, 7'b0000110);
      chk("rp_rst_rpc", redirect_pc, 64'h0);
      tick();
      reset = 1;
      settle();
      chk("rp_rel_ctl", ctl, 7'b1000100);
      chk("rp_rel_brt", br_total, 0);
      chk("rp_rel_stc", stall_cycles, 0);
      if_busy = 0;
      settle();
      chk("rp_run_ctl", ctl, 7'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
